ddr2_arbiter: RTL

- Shares the single DDR2 controller port between two cache clients: client 0 is the instruction cache, client 1 is the data cache.
- Each client drives the port exactly as a cache drives DDR2 today: one-cycle enable pulses, a read flag, and a line-aligned address.
- The arbiter buffers client requests and serialises them with one outstanding DDR2 transaction at a time.
- Only read completions are routed back to the owning client.

---
 rtl/ddr2_arb_pkg.sv | 18 +
 rtl/ddr2_arbiter_req_fifo.sv | 47 ++++
 rtl/ddr2_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ddr2_arb_pkg.sv
// rtl/ddr2_arb_pkg.sv - shared types and defaults for the DDR2 two-client arbiter
package ddr2_arb_pkg;

    localparam int ADDR_W_DEF = 27;
    localparam int LINE_W_DEF = 128;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  read;
        logic [ADDR_W_DEF-1:0] addr;
        logic [LINE_W_DEF-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/ddr2_arbiter_req_fifo.sv
// rtl/ddr2_arbiter_req_fifo.sv - per-client request FIFO, power-of-two depth
module req_fifo
    import ddr2_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  mem_req_t data_i,
    input  logic     pop_i,
    output mem_req_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    mem_req_t    mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ddr2_arbiter.sv
// rtl/ddr2_arbiter.sv - shares one DDR2 port between I-cache (c0) and D-cache (c1)
// DDR2_ARB_FIXED_PRIO_EN: c0 always wins ties instead of round-robin.
module ddr2_arbiter
    import ddr2_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_enable,
    input  logic              c0_read,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [LINE_W-1:0] c0_wdata,
    input  logic              c1_enable,
    input  logic              c1_read,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [LINE_W-1:0] c1_wdata,
    output logic              c0_available,
    output logic [LINE_W-1:0] c0_rdata,
    output logic              c1_available,
    output logic [LINE_W-1:0] c1_rdata,
    output logic              mem_enable,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_available,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              overflow
);

    arb_state_t        state_q, state_d;
    logic              owner_q;
    logic              read_q;
    logic              mem_enable_q;
    logic              mem_read_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic              c0_avail_q, c1_avail_q;
    logic [LINE_W-1:0] c0_rdata_q, c1_rdata_q;
    logic              overflow_q;
`ifndef DDR2_ARB_FIXED_PRIO_EN
    logic              rr_q;
`endif

    mem_req_t c0_req, c1_req, head0, head1, head_win;
    logic     full0, full1, empty0, empty1;
    logic     grant, win, pop0, pop1, done;

    assign c0_req = '{read: c0_read, addr: c0_addr, wdata: c0_wdata};
    assign c1_req = '{read: c1_read, addr: c1_addr, wdata: c1_wdata};

    req_fifo #(.DEPTH(QDEPTH)) u_q0 (
        .clk(clk), .rst(rst), .push_i(c0_enable), .data_i(c0_req),
        .pop_i(pop0), .data_o(head0), .full_o(full0), .empty_o(empty0)
    );

    req_fifo #(.DEPTH(QDEPTH)) u_q1 (
        .clk(clk), .rst(rst), .push_i(c1_enable), .data_i(c1_req),
        .pop_i(pop1), .data_o(head1), .full_o(full1), .empty_o(empty1)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty0 || !empty1) begin
                    grant   = 1'b1;
                    state_d = WAIT;
`ifdef DDR2_ARB_FIXED_PRIO_EN
                    win = empty0;
`else
                    // On a tie, the client that did not own the last transaction wins.
                    win = (!empty0 && !empty1) ? ~rr_q : empty0;
`endif
                end
            end
            WAIT: begin
                if (mem_available) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop0     = grant && !win;
    assign pop1     = grant && win;
    assign head_win = win ? head1 : head0;
    assign done     = (state_q == WAIT) && mem_available;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

`ifndef DDR2_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rr_q <= 1'b0;
        else if (done) rr_q <= owner_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            read_q       <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            c0_avail_q   <= 1'b0;
            c1_avail_q   <= 1'b0;
            c0_rdata_q   <= '0;
            c1_rdata_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            mem_enable_q <= grant;
            c0_avail_q   <= 1'b0;
            c1_avail_q   <= 1'b0;
            if (grant) begin
                mem_read_q  <= head_win.read;
                mem_addr_q  <= head_win.addr;
                mem_wdata_q <= head_win.wdata;
                owner_q     <= win;
                read_q      <= head_win.read;
            end
            // Write completions are absorbed here; only reads go back to a cache.
            if (done && read_q) begin
                if (owner_q) begin
                    c1_rdata_q <= mem_rdata;
                    c1_avail_q <= 1'b1;
                end else begin
                    c0_rdata_q <= mem_rdata;
                    c0_avail_q <= 1'b1;
                end
            end
            if ((c0_enable && full0) || (c1_enable && full1)) overflow_q <= 1'b1;
        end
    end

    assign mem_enable   = mem_enable_q;
    assign mem_read     = mem_read_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign c0_available = c0_avail_q;
    assign c1_available = c1_avail_q;
    assign c0_rdata     = c0_rdata_q;
    assign c1_rdata     = c1_rdata_q;
    assign overflow     = overflow_q;

endmodule
